// File: rtl/ro_puf_pkg.sv
// ro_puf_pkg: shared states and schedule helpers for the RO PUF sequencer
package ro_puf_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_SETTLE, S_COUNT, S_SAMPLE, S_COMPARE, S_DONE
  } ro_seq_state_t;
  function automatic int pair_cycles(int settle, int win, int sync);
    return 2 + settle + win + sync;
  endfunction
  function automatic int timer_w(int win, int settle, int sync);
    int m;
    m = win > settle ? win : settle;
    m = m > sync ? m : sync;
    return $clog2(m + 1);
  endfunction
  localparam int TIMER_W = timer_w(1000, 4, 3);
endpackage

// File: rtl/ro_puf_sequencer_if.sv
// ro_puf_sequencer_if: control/readout bundle between sequencer and RO datapath
interface ro_puf_sequencer_if #(
  parameter int N_PAIRS = 8,
  parameter int SEL_W   = 4,
  parameter int CNT_W   = 16
);
  logic               start, busy, cnt_clr, cnt_en, valid, tie, sat;
  logic [SEL_W-1:0]   sel_a, sel_b;
  logic [CNT_W-1:0]   cnt_a, cnt_b;
  logic [N_PAIRS-1:0] response;
  modport master (
    input  start, cnt_a, cnt_b,
    output busy, sel_a, sel_b, cnt_clr, cnt_en, response, valid, tie, sat
  );
  modport slave (
    output start, cnt_a, cnt_b,
    input  busy, sel_a, sel_b, cnt_clr, cnt_en, response, valid, tie, sat
  );
endinterface

// File: rtl/ro_puf_window_timer.sv
// ro_puf_window_timer: loadable down-counter flagging the last cycle of a phase
module ro_puf_window_timer
  import ro_puf_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
  assign expire = cnt_q == W'(1);
endmodule

// File: rtl/ro_puf_sequencer.sv
// ro_puf_sequencer: cycle-exact clear/settle/count/sample/compare schedule per RO pair
module ro_puf_sequencer
  import ro_puf_pkg::*;
#(
  parameter int N_PAIRS       = 8,
  parameter int SEL_W         = 4,
  parameter int CNT_W         = 16,
  parameter int WIN_CYCLES    = 1000,
  parameter int SETTLE_CYCLES = 4,
  parameter int SYNC_CYCLES   = 3
) (
  input logic               clk,
  input logic               rst,
  ro_puf_sequencer_if.master bus
);
  localparam int TW = timer_w(WIN_CYCLES, SETTLE_CYCLES, SYNC_CYCLES);
  localparam int KW = N_PAIRS > 1 ? $clog2(N_PAIRS) : 1;
  ro_seq_state_t      state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic [N_PAIRS-1:0] response_q, response_d;
  logic               tie_q, tie_d, sat_q, sat_d;
  logic [SEL_W-1:0]   sel_a_q, sel_a_d, sel_b_q, sel_b_d;
  logic               busy_q, busy_d, cnt_clr_q, cnt_clr_d, cnt_en_q, cnt_en_d, valid_q, valid_d;
  logic [TW-1:0]      load_val;
  logic               load, expire, last, in_pair;
  assign last = k_q == KW'(N_PAIRS - 1);
  ro_puf_window_timer #(.W(TW)) u_timer (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .expire(expire)
  );
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    response_d = response_q;
    tie_d      = tie_q;
    sat_d      = sat_q;
    case (state_q)
      S_IDLE: if (bus.start) begin
        state_d    = S_CLEAR;
        k_d        = '0;
        response_d = '0;
        tie_d      = 1'b0;
        sat_d      = 1'b0;
      end
      S_CLEAR:  state_d = S_SETTLE;
      S_SETTLE: state_d = expire ? S_COUNT : S_SETTLE;
      S_COUNT:  state_d = expire ? S_SAMPLE : S_COUNT;
      S_SAMPLE: state_d = expire ? S_COMPARE : S_SAMPLE;
      S_COMPARE: begin
        response_d[k_q] = bus.cnt_a > bus.cnt_b;
        tie_d           = tie_q | (bus.cnt_a == bus.cnt_b);
        sat_d           = sat_q | (bus.cnt_a == {CNT_W{1'b1}}) | (bus.cnt_b == {CNT_W{1'b1}});
        state_d         = last ? S_DONE : S_CLEAR;
        k_d             = last ? k_q : k_q + 1'b1;
      end
      default:  state_d = S_IDLE;
    endcase
    // the timer reloads on every state change; only SETTLE/COUNT/SAMPLE consume it
    load      = state_d != state_q;
    load_val  = state_d == S_SETTLE ? TW'(SETTLE_CYCLES) :
                state_d == S_COUNT  ? TW'(WIN_CYCLES) : TW'(SYNC_CYCLES);
    in_pair   = state_d inside {[S_CLEAR:S_COMPARE]};
    sel_a_d   = in_pair ? SEL_W'({k_d, 1'b0}) : '0;
    sel_b_d   = in_pair ? SEL_W'({k_d, 1'b1}) : '0;
    busy_d    = state_d != S_IDLE;
    cnt_clr_d = state_d == S_CLEAR;
    cnt_en_d  = state_d == S_COUNT;
    valid_d   = state_d == S_DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      response_q <= '0;
      tie_q      <= 1'b0;
      sat_q      <= 1'b0;
      sel_a_q    <= '0;
      sel_b_q    <= '0;
      busy_q     <= 1'b0;
      cnt_clr_q  <= 1'b0;
      cnt_en_q   <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      response_q <= response_d;
      tie_q      <= tie_d;
      sat_q      <= sat_d;
      sel_a_q    <= sel_a_d;
      sel_b_q    <= sel_b_d;
      busy_q     <= busy_d;
      cnt_clr_q  <= cnt_clr_d;
      cnt_en_q   <= cnt_en_d;
      valid_q    <= valid_d;
    end
  end
  assign bus.busy     = busy_q;
  assign bus.sel_a    = sel_a_q;
  assign bus.sel_b    = sel_b_q;
  assign bus.cnt_clr  = cnt_clr_q;
  assign bus.cnt_en   = cnt_en_q;
  assign bus.response = response_q;
  assign bus.valid    = valid_q;
  assign bus.tie      = tie_q;
  assign bus.sat      = sat_q;
endmodule

// File: tb/tb_ro_puf_sequencer.sv
// tb_ro_puf_sequencer: scoreboard bench for the RO PUF sequencer (N=4, WIN=16, SETTLE=2, SYNC=3)
module tb_ro_puf_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ro_puf_sequencer_if #(.N_PAIRS(4), .SEL_W(4), .CNT_W(16)) bus ();
  ro_puf_sequencer #(
    .N_PAIRS(4), .SEL_W(4), .CNT_W(16),
    .WIN_CYCLES(16), .SETTLE_CYCLES(2), .SYNC_CYCLES(3)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  logic [15:0] ca[4];
  logic [15:0] cb[4];
  assign bus.cnt_a = ca[bus.sel_a[2:1]];
  assign bus.cnt_b = cb[bus.sel_a[2:1]];
  int checks = 0;
  int errors = 0;
  logic [5:0] exp_q[$];
  logic [5:0] got_q[$];
  int vcyc_q[$];
  logic [3:0] sa_q[$];
  logic [3:0] sb_q[$];
  bit busy_tr[0:299];
  bit en_tr[0:299];
  bit tie_tr[0:299];
  int en_cnt[4];
  int clr_n;

  function automatic logic [5:0] model();
    logic [3:0] r;
    logic t, s;
    r = '0; t = 1'b0; s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      r[i] = ca[i] > cb[i];
      t = t | (ca[i] == cb[i]);
      s = s | (ca[i] == 16'hFFFF) | (cb[i] == 16'hFFFF);
    end
    return {r, t, s};
  endfunction

  task automatic kick();
    @(posedge clk); #1 bus.start = 1'b1;
    exp_q.push_back(model());
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic collect(input int ncyc, input int s1, input int s2, input int hold_to);
    got_q.delete(); vcyc_q.delete(); sa_q.delete(); sb_q.delete();
    clr_n = 0;
    for (int i = 0; i < 4; i++) en_cnt[i] = 0;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      busy_tr[n] = bus.busy;
      en_tr[n]   = bus.cnt_en;
      tie_tr[n]  = bus.tie;
      if (bus.cnt_en) en_cnt[bus.sel_a[2:1]]++;
      if (bus.cnt_clr) begin
        clr_n++;
        sa_q.push_back(bus.sel_a);
        sb_q.push_back(bus.sel_b);
      end
      if (bus.valid) begin
        vcyc_q.push_back(n);
        got_q.push_back({bus.response, bus.tie, bus.sat});
      end
      bus.start = (n == s1) || (n == s2) || (n <= hold_to);
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    ca = '{16'd0, 16'd0, 16'd0, 16'd0};
    cb = '{16'd0, 16'd0, 16'd0, 16'd0};
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.cnt_en, bus.cnt_clr, bus.valid, bus.tie, bus.sat} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 000000", {bus.busy, bus.cnt_en, bus.cnt_clr, bus.valid, bus.tie, bus.sat});
    end
    checks++;
    if (bus.response !== 4'b0) begin
      errors++; $display("FAIL reset_resp: got %b want 0000", bus.response);
    end
    checks++;
    if ({bus.sel_a, bus.sel_b} !== 8'h00) begin
      errors++; $display("FAIL reset_sel: got %h want 00", {bus.sel_a, bus.sel_b});
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_nominal();
    logic [5:0] g, e;
    int first_en;
    ca = '{16'd100, 16'd50, 16'd200, 16'd70};
    cb = '{16'd90, 16'd60, 16'd150, 16'd80};
    kick();
    collect(100, -1, -1, 0);
    g = got_q.size() > 0 ? got_q.pop_front() : 'x;
    e = exp_q.pop_front();
    checks++;
    if (g !== e || g !== 6'b0101_00) begin
      errors++; $display("FAIL nom_result: got %b want %b", g, e);
    end
    checks++;
    if (vcyc_q.size() != 1 || vcyc_q[0] != 93) begin
      errors++; $display("FAIL nom_valid_time: got %0d valids first at %0d want 1 at 93",
                         vcyc_q.size(), vcyc_q.size() > 0 ? vcyc_q[0] : -1);
    end
    first_en = -1;
    for (int n = 100; n >= 1; n--) if (en_tr[n]) first_en = n;
    checks++;
    if (first_en != 4) begin
      errors++; $display("FAIL nom_first_en: got %0d want 4", first_en);
    end
    checks++;
    if ({busy_tr[1], busy_tr[93], busy_tr[94]} !== 3'b110) begin
      errors++; $display("FAIL nom_busy: got %b want 110", {busy_tr[1], busy_tr[93], busy_tr[94]});
    end
  endtask

  task automatic test_window();
    logic [5:0] g, e;
    for (int i = 0; i < 4; i++) begin
      ca[i] = 16'($urandom_range(0, 65534));
      cb[i] = 16'($urandom_range(0, 65534));
    end
    kick();
    collect(100, -1, -1, 0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (en_cnt[i] != 16) begin
        errors++; $display("FAIL win_en_pair%0d: got %0d want 16", i, en_cnt[i]);
      end
    end
    checks++;
    if (clr_n != 4) begin
      errors++; $display("FAIL win_clr_count: got %0d want 4", clr_n);
    end
    for (int i = 0; i < 4 && i < sa_q.size(); i++) begin
      checks++;
      if (sa_q[i] !== 4'(2 * i) || sb_q[i] !== 4'(2 * i + 1)) begin
        errors++; $display("FAIL win_sel_pair%0d: got (%0d,%0d) want (%0d,%0d)", i, sa_q[i], sb_q[i], 2 * i, 2 * i + 1);
      end
    end
    g = got_q.size() > 0 ? got_q.pop_front() : 'x;
    e = exp_q.pop_front();
    checks++;
    if (g !== e) begin
      errors++; $display("FAIL win_result: got %b want %b", g, e);
    end
  endtask

  task automatic test_tie_sat();
    logic [5:0] g, e;
    ca = '{16'd10, 16'd33, 16'hFFFF, 16'd5};
    cb = '{16'd20, 16'd33, 16'd100, 16'd9};
    kick();
    collect(120, -1, -1, 0);
    g = got_q.size() > 0 ? got_q.pop_front() : 'x;
    e = exp_q.pop_front();
    checks++;
    if (g !== e || g !== 6'b0100_11) begin
      errors++; $display("FAIL ts_result: got %b want %b", g, e);
    end
    checks++;
    if ({bus.response, bus.tie, bus.sat} !== 6'b0100_11) begin
      errors++; $display("FAIL ts_hold: got %b want 010011", {bus.response, bus.tie, bus.sat});
    end
    ca = '{16'd100, 16'd50, 16'd200, 16'd70};
    cb = '{16'd90, 16'd60, 16'd150, 16'd80};
    kick();
    collect(100, -1, -1, 0);
    checks++;
    if (tie_tr[1] !== 1'b0) begin
      errors++; $display("FAIL ts_flag_clear: got %b want 0", tie_tr[1]);
    end
    g = got_q.size() > 0 ? got_q.pop_front() : 'x;
    e = exp_q.pop_front();
    checks++;
    if (g !== e) begin
      errors++; $display("FAIL ts_rerun: got %b want %b", g, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] g, e;
    int idle_busy;
    ca = '{16'd100, 16'd50, 16'd200, 16'd70};
    cb = '{16'd90, 16'd60, 16'd150, 16'd80};
    kick();
    collect(130, 50, 93, 0);
    idle_busy = 0;
    for (int n = 94; n <= 130; n++) idle_busy += int'(busy_tr[n]);
    checks++;
    if (vcyc_q.size() != 1 || idle_busy != 0) begin
      errors++; $display("FAIL b2b_ignored: got %0d valids busy_after=%0d want 1 and 0", vcyc_q.size(), idle_busy);
    end
    g = got_q.size() > 0 ? got_q.pop_front() : 'x;
    e = exp_q.pop_front();
    checks++;
    if (g !== e) begin
      errors++; $display("FAIL b2b_result: got %b want %b", g, e);
    end
    ca = '{16'd10, 16'd33, 16'hFFFF, 16'd5};
    cb = '{16'd20, 16'd33, 16'd100, 16'd9};
    kick();
    exp_q.push_back(6'b0100_11);
    collect(200, -1, -1, 100);
    checks++;
    if (vcyc_q.size() != 2 || vcyc_q[0] != 93 || vcyc_q[1] != 187) begin
      errors++; $display("FAIL held_valid_times: got %0d valids last at %0d want 2 at 93,187",
                         vcyc_q.size(), vcyc_q.size() > 0 ? vcyc_q[vcyc_q.size() - 1] : -1);
    end
    checks++;
    if ({tie_tr[94], tie_tr[95], busy_tr[95], busy_tr[189]} !== 4'b1010) begin
      errors++; $display("FAIL held_restart: got %b want 1010", {tie_tr[94], tie_tr[95], busy_tr[95], busy_tr[189]});
    end
    for (int r = 0; r < 2; r++) begin
      g = got_q.size() > 0 ? got_q.pop_front() : 'x;
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++; $display("FAIL held_result%0d: got %b want %b", r, g, e);
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [5:0] g, e;
    ca = '{16'd100, 16'd50, 16'd200, 16'd70};
    cb = '{16'd90, 16'd60, 16'd150, 16'd80};
    kick();
    collect(55, -1, -1, 0);
    checks++;
    if (en_tr[55] !== 1'b1 || bus.sel_a !== 4'd4) begin
      errors++; $display("FAIL abort_in_count: got en=%b sel_a=%0d want 1 4", en_tr[55], bus.sel_a);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.busy, bus.cnt_en, bus.valid, bus.response} !== 7'b0) begin
      errors++; $display("FAIL abort_state: got %b want 0000000", {bus.busy, bus.cnt_en, bus.valid, bus.response});
    end
    rst = 1'b0;
    exp_q.delete();
    collect(40, -1, -1, 0);
    checks++;
    if (vcyc_q.size() != 0) begin
      errors++; $display("FAIL abort_no_valid: got %0d valids want 0", vcyc_q.size());
    end
    kick();
    collect(100, -1, -1, 0);
    g = got_q.size() > 0 ? got_q.pop_front() : 'x;
    e = exp_q.pop_front();
    checks++;
    if (g !== e || vcyc_q.size() != 1 || vcyc_q[0] != 93) begin
      errors++; $display("FAIL abort_rerun: got %b want %b (valids %0d)", g, e, vcyc_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_window();
    test_tie_sat();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
